// File: rtl/reg_snap_ring_pkg.sv
// Shared constants for the register-bank snapshot ring.
package reg_snap_ring_pkg;
  localparam int unsigned DROP_CNT_W = 16;
endpackage

// File: rtl/rowo_dpram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
module rowo_dpram #(
  parameter int unsigned rdw   = 32,
  parameter int unsigned wdw   = 32,
  parameter int unsigned raw   = 7,
  parameter int unsigned depth = 1 << raw
) (
  input  logic           clk,
  input  logic           wren,
  input  logic [raw-1:0] wraddr,
  input  logic [wdw-1:0] wrdata,
  input  logic           rden,
  input  logic [raw-1:0] rdaddr,
  output logic [rdw-1:0] rddata
);

  logic [wdw-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wren && (32'(wraddr) < depth)) mem[wraddr] <= wrdata;
  end

  // Addresses past the populated depth read as zero.
  always_ff @(posedge clk) begin
    if (rden) begin
      if (32'(rdaddr) < depth) rddata <= rdw'(mem[rdaddr]);
      else                     rddata <= '0;
    end
  end

endmodule

// File: rtl/reg_snap_ring.sv
// Coherent snapshot of a register bank into a multi-slot RAM ring; the host
// reads the oldest slot word-by-word and frees it with pop.
module reg_snap_ring
  import reg_snap_ring_pkg::*;
#(
  parameter int unsigned  DW        = 32,
  parameter int unsigned  REG_NUM   = 10,
  parameter int unsigned  SLOT_NUM  = 8,
  parameter bit           OVERWRITE = 1'b0,
  localparam int unsigned aw        = $clog2(SLOT_NUM*REG_NUM),
  localparam int unsigned sw        = $clog2(REG_NUM),
  localparam int unsigned pw        = $clog2(SLOT_NUM),
  localparam int unsigned lw        = $clog2(SLOT_NUM+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_NUM*DW-1:0] seq_reg,
  input  logic                  write_trigger,
  output logic                  write_busy,
  output logic [sw-1:0]         select,
  input  logic                  pop,
  output logic [lw-1:0]         level,
  output logic                  empty,
  output logic                  full,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  reg_rd,
  input  logic [sw-1:0]         reg_addr,
  output logic                  reg_ready,
  output logic [DW-1:0]         reg_readdata
);

  logic                  wr_active_q, wr_active_d;
  logic [sw-1:0]         select_q, select_d;
  logic [pw-1:0]         head_idx_q, head_idx_d, tail_idx_q, tail_idx_d;
  logic [aw-1:0]         head_base_q, head_base_d, tail_base_q, tail_base_d;
  logic [lw-1:0]         level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ready_q, ready_d, rd_ok_q, rd_ok_d;
  logic [DW-1:0]         shadow_q [REG_NUM];

  logic          accept, commit, pop_eff, ovw_adv, tail_adv, drop_inc;
  logic [aw-1:0] ram_wraddr, ram_rdaddr;
  logic [DW-1:0] ram_rddata;

  // Per-cycle ring events; overwrite and pop share one tail advance.
  always_comb begin
    accept   = write_trigger && !wr_active_q && (!full_q || OVERWRITE);
    commit   = wr_active_q && (select_q == sw'(REG_NUM-1));
    pop_eff  = pop && !empty_q;
    ovw_adv  = accept && full_q;
    tail_adv = pop_eff || ovw_adv;
    drop_inc = (write_trigger && !accept) || (ovw_adv && !pop_eff);
  end

  always_comb begin
    wr_active_d = wr_active_q;
    select_d    = select_q;
    head_idx_d  = head_idx_q;
    head_base_d = head_base_q;
    tail_idx_d  = tail_idx_q;
    tail_base_d = tail_base_q;
    drop_d      = drop_q;

    if (accept) begin
      wr_active_d = 1'b1;
      select_d    = '0;
    end else if (wr_active_q) begin
      if (commit) begin
        wr_active_d = 1'b0;
        select_d    = '0;
      end else begin
        select_d = select_q + 1'b1;
      end
    end

    if (commit) begin
      if (head_idx_q == pw'(SLOT_NUM-1)) begin
        head_idx_d  = '0;
        head_base_d = '0;
      end else begin
        head_idx_d  = head_idx_q + 1'b1;
        head_base_d = head_base_q + aw'(REG_NUM);
      end
    end

    if (tail_adv) begin
      if (tail_idx_q == pw'(SLOT_NUM-1)) begin
        tail_idx_d  = '0;
        tail_base_d = '0;
      end else begin
        tail_idx_d  = tail_idx_q + 1'b1;
        tail_base_d = tail_base_q + aw'(REG_NUM);
      end
    end

    // Commit and overwrite never coincide (commit needs a busy engine).
    level_d = level_q + lw'(commit) - lw'(tail_adv);
    empty_d = (level_d == '0);
    full_d  = (level_d == lw'(SLOT_NUM));

    if (drop_inc && (drop_q != '1)) drop_d = drop_q + 1'b1;

    ready_d = reg_rd && !ready_q;
    rd_ok_d = reg_rd && !ready_q && !empty_q && (32'(reg_addr) < REG_NUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_active_q <= 1'b0;
      select_q    <= '0;
      head_idx_q  <= '0;
      head_base_q <= '0;
      tail_idx_q  <= '0;
      tail_base_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      drop_q      <= '0;
      ready_q     <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      wr_active_q <= wr_active_d;
      select_q    <= select_d;
      head_idx_q  <= head_idx_d;
      head_base_q <= head_base_d;
      tail_idx_q  <= tail_idx_d;
      tail_base_q <= tail_base_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
      ready_q     <= ready_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  // Shadow copy decouples the slot contents from later bank changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < REG_NUM; i++) shadow_q[i] <= seq_reg[i*DW +: DW];
    end
  end

  assign ram_wraddr = head_base_q + aw'(select_q);
  assign ram_rdaddr = tail_base_q + aw'(reg_addr);

  rowo_dpram #(
    .rdw   (DW),
    .wdw   (DW),
    .raw   (aw),
    .depth (SLOT_NUM*REG_NUM)
  ) u_ram (
    .clk    (clk),
    .wren   (wr_active_q),
    .wraddr (ram_wraddr),
    .wrdata (shadow_q[select_q]),
    .rden   (1'b1),
    .rdaddr (ram_rdaddr),
    .rddata (ram_rddata)
  );

  assign write_busy   = write_trigger | wr_active_q;
  assign select       = select_q;
  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign drop_cnt     = drop_q;
  assign reg_ready    = ready_q;
  assign reg_readdata = rd_ok_q ? ram_rddata : '0;

endmodule

// File: tb/tb_reg_snap_ring.sv
// Drives a drop-mode and an overwrite-mode ring with shared stimulus and checks
// both against a queue-of-snapshots reference model.
module tb_reg_snap_ring;
  localparam int unsigned DW = 32, REG_NUM = 10, SLOT_NUM = 8;
  localparam int unsigned SW = $clog2(REG_NUM), LW = $clog2(SLOT_NUM+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, write_trigger, pop, reg_rd;
  logic [REG_NUM*DW-1:0] seq_reg;
  logic [SW-1:0]         reg_addr;
  logic                  busy_w [2];
  logic [SW-1:0]         select_w [2];
  logic [LW-1:0]         level_w [2];
  logic                  empty_w [2], full_w [2], ready_w [2];
  logic [15:0]           drop_w [2];
  logic [DW-1:0]         data_w [2];

  reg_snap_ring #(.DW(DW), .REG_NUM(REG_NUM), .SLOT_NUM(SLOT_NUM), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .seq_reg(seq_reg), .write_trigger(write_trigger),
    .write_busy(busy_w[0]), .select(select_w[0]), .pop(pop), .level(level_w[0]),
    .empty(empty_w[0]), .full(full_w[0]), .drop_cnt(drop_w[0]), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_ready(ready_w[0]), .reg_readdata(data_w[0]));

  reg_snap_ring #(.DW(DW), .REG_NUM(REG_NUM), .SLOT_NUM(SLOT_NUM), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .seq_reg(seq_reg), .write_trigger(write_trigger),
    .write_busy(busy_w[1]), .select(select_w[1]), .pop(pop), .level(level_w[1]),
    .empty(empty_w[1]), .full(full_w[1]), .drop_cnt(drop_w[1]), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_ready(ready_w[1]), .reg_readdata(data_w[1]));

  // Reference model state: committed snapshots oldest-first, pending write, drops.
  logic [REG_NUM*DW-1:0] slots0[$], slots1[$];
  logic [DW-1:0]         exp0[$], exp1[$];
  logic [REG_NUM*DW-1:0] pend_m [2];
  int                    busy_m [2];
  int                    drops_m [2];
  int                    errors = 0, checks = 0, busy_hi = 0;
  bit                    chk_en = 1'b0;
  logic                  rst_next = 1'b1;
  logic [REG_NUM*DW-1:0] seq_next = '0;

  function automatic int qsize(input int k);
    return (k == 0) ? slots0.size() : slots1.size();
  endfunction
  function automatic logic [REG_NUM*DW-1:0] qfront(input int k);
    return (k == 0) ? slots0[0] : slots1[0];
  endfunction
  function automatic void qpop(input int k);
    if (k == 0) void'(slots0.pop_front()); else void'(slots1.pop_front());
  endfunction
  function automatic void qpush(input int k, input logic [REG_NUM*DW-1:0] v);
    if (k == 0) slots0.push_back(v); else slots1.push_back(v);
  endfunction
  function automatic int esize(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction
  function automatic logic [DW-1:0] epop(input int k);
    return (k == 0) ? exp0.pop_front() : exp1.pop_front();
  endfunction
  function automatic void epush(input int k, input logic [DW-1:0] v);
    if (k == 0) exp0.push_back(v); else exp1.push_back(v);
  endfunction
  function automatic void bump_drop(input int k);
    if (drops_m[k] < 65535) drops_m[k]++;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, req, $time);
    end
  endtask

  task automatic check_status();
    int n;
    for (int k = 0; k < 2; k++) begin
      n = qsize(k);
      chk("level", k, 64'(level_w[k]), 64'(n));
      chk("empty", k, 64'(empty_w[k]), 64'(n == 0));
      chk("full", k, 64'(full_w[k]), 64'(n == SLOT_NUM));
      chk("drop_cnt", k, 64'(drop_w[k]), 64'(drops_m[k]));
      chk("select", k, 64'(select_w[k]), (busy_m[k] > 0) ? 64'(REG_NUM - busy_m[k]) : 64'd0);
    end
  endtask

  // One model clock edge, from the inputs presented in the current cycle.
  task automatic model_step(input int k);
    int n;
    bit acc, com, pe;
    logic [DW-1:0] ev;
    logic [REG_NUM*DW-1:0] fr;
    if (rst) begin
      while (qsize(k) > 0) qpop(k);
      while (esize(k) > 0) void'(epop(k));
      busy_m[k] = 0;
      drops_m[k] = 0;
      return;
    end
    n = qsize(k);
    if (reg_rd) begin
      if (n == 0 || int'(reg_addr) >= REG_NUM) ev = '0;
      else begin
        fr = qfront(k);
        ev = fr[int'(reg_addr)*DW +: DW];
      end
      epush(k, ev);
    end
    com = (busy_m[k] == 1);
    acc = write_trigger && (busy_m[k] == 0) && (n < SLOT_NUM || k == 1);
    pe  = pop && (n > 0);
    if (pe) qpop(k);
    else if (acc && n == SLOT_NUM) begin
      qpop(k);
      bump_drop(k);
    end
    if (write_trigger && !acc) bump_drop(k);
    if (busy_m[k] > 0) busy_m[k]--;
    if (com) qpush(k, pend_m[k]);
    if (acc) begin
      busy_m[k] = REG_NUM;
      pend_m[k] = seq_reg;
    end
  endtask

  task automatic cyc(input bit t, input bit p, input bit r, input int unsigned a);
    @(negedge clk);
    if (chk_en) check_status();
    rst = rst_next;
    seq_reg = seq_next;
    write_trigger = t;
    pop = p;
    reg_rd = r;
    reg_addr = SW'(a);
    #1;
    if (busy_w[0]) busy_hi++;
    for (int k = 0; k < 2; k++) begin
      if (chk_en) chk("write_busy", k, 64'(busy_w[k]), 64'(t || busy_m[k] > 0));
      model_step(k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic rd(input int unsigned a);
    cyc(1'b0, 1'b0, 1'b1, a);
    cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic set_tag(input int tag);
    for (int i = 0; i < REG_NUM; i++)
      seq_next[i*DW +: DW] = {16'(tag), 8'(i), 8'($urandom)};
  endtask

  task automatic snapshot(input int tag, input bit p);
    set_tag(tag);
    cyc(1'b1, p, 1'b0, 0);
    idle(REG_NUM);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rd($urandom_range(0, REG_NUM - 1));
      cyc(1'b0, 1'b1, 1'b0, 0);
    end
  endtask

  // Scoreboard monitor: every presented read response is matched to the model.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ready_w[k] === 1'b1) begin
          if (esize(k) > 0) begin
            e = epop(k);
            chk("reg_readdata", k, 64'(data_w[k]), 64'(e));
          end else if (chk_en) begin
            chk("unexpected_ready", k, 64'(ready_w[k]), 64'd0);
          end
        end else if (esize(k) > 0) begin
          e = epop(k);
          chk("reg_ready", k, 64'(ready_w[k]), 64'd1);
        end
      end
    end
  end

  initial begin
    bit prev_r;
    bit r;
    rst = 1'b1; write_trigger = 1'b0; pop = 1'b0; reg_rd = 1'b0;
    reg_addr = '0; seq_reg = '0;
    busy_m = '{0, 0};
    drops_m = '{0, 0};
    idle(3);
    rst_next = 1'b0;
    idle(1);
    chk_en = 1'b1;

    // Single snapshot with coherence: bank changes right after the trigger.
    for (int i = 0; i < REG_NUM; i++) seq_next[i*DW +: DW] = 32'hA000 + 32'(i);
    busy_hi = 0;
    cyc(1'b1, 1'b0, 1'b0, 0);
    seq_next = '1;
    idle(REG_NUM + 2);
    chk("busy_cycles", 0, 64'(busy_hi), 64'(REG_NUM + 1));
    chk("level_one", 0, 64'(level_w[0]), 64'd1);
    for (int a = 0; a < REG_NUM + 2; a++) rd(a);
    cyc(1'b0, 1'b1, 1'b0, 0);
    rd(3);

    // Nine snapshots into eight slots, then drain.
    for (int t = 1; t <= 9; t++) snapshot(t, 1'b0);
    chk("full_drop0", 0, 64'(full_w[0]), 64'd1);
    chk("drop_ovw", 1, 64'(drop_w[1]), 64'd1);
    rd(0);
    drain(SLOT_NUM);
    rd(0);

    // Refill, then trigger with a same-cycle pop.
    for (int t = 11; t <= 18; t++) snapshot(t, 1'b0);
    snapshot(19, 1'b1);
    rd(0);
    drain(SLOT_NUM + 1);

    // Trigger while busy, pop at the commit edge, retrigger right after commit.
    snapshot(30, 1'b0);
    set_tag(31);
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int j = 1; j <= REG_NUM; j++) cyc(j == 3, j == REG_NUM, 1'b0, 0);
    set_tag(32);
    cyc(1'b1, 1'b0, 1'b0, 0);
    idle(REG_NUM);
    drain(3);

    // Reset in the middle of a write, then a fresh snapshot.
    snapshot(40, 1'b0);
    set_tag(41);
    cyc(1'b1, 1'b0, 1'b0, 0);
    idle(4);
    rst_next = 1'b1;
    idle(1);
    rst_next = 1'b0;
    idle(2);
    snapshot(42, 1'b0);
    for (int a = 0; a < REG_NUM; a++) rd(a);
    drain(1);

    // Random traffic.
    prev_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < REG_NUM; w++) seq_next[w*DW +: DW] = $urandom;
      r = !prev_r && ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, r, $urandom_range(0, REG_NUM + 1));
      prev_r = r;
    end
    idle(REG_NUM + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_snap_ring.md
# reg_snap_ring

Parametrised register-bank snapshot buffer. On each accepted trigger it captures the whole `seq_reg` bank coherently and writes it word-by-word into one slot of a multi-slot ring held in a `rowo_dpram`. The host reads the oldest slot through the AXI register interface and frees it with `pop`. It sits between the sequencer register bank and the AXI slave, and supersedes single-slot register-to-RAM copying. It adds snapshot coherence, slot queueing, full/empty status and an optional overwrite-oldest mode.

## Interface
Parameters:
- `DW`, 32, register/data word width
- `REG_NUM`, 10, registers per snapshot (≥2)
- `SLOT_NUM`, 8, snapshot slots in ring (≥2)
- `OVERWRITE`, 0, 1 = a trigger when full discards oldest slot; 0 = the trigger is dropped

Derived widths: `aw=$clog2(SLOT_NUM*REG_NUM)`, `sw=$clog2(REG_NUM)`, `pw=$clog2(SLOT_NUM)`, `lw=$clog2(SLOT_NUM+1)`.

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `seq_reg` in REG_NUM*DW: register bank; word i = bits [DW*i+DW-1:DW*i]
- `write_trigger` in 1: snapshot request, single-cycle pulse
- `write_busy` out 1: `write_trigger | wr_active`, combinational
- `select` out sw: word index currently being written
- `pop` in 1: free the oldest slot
- `level` out lw: committed slots
- `empty` out 1: level==0
- `full` out 1: level==SLOT_NUM
- `drop_cnt` out 16: dropped/overwritten snapshot count, saturating at 16'hFFFF
- `reg_rd` in 1: host read request, held until `reg_ready`
- `reg_addr` in sw: word offset within the oldest slot
- `reg_ready` out 1: read acknowledge
- `reg_readdata` out DW: read data

Reset values: `select`, `level`, `drop_cnt`, `reg_ready`, `reg_readdata` = 0; `empty`=1; `full`=0; write engine idle.

## Operation
- Accept rule: `write_trigger` is accepted iff the engine is idle AND (!full OR OVERWRITE). On acceptance, all of `seq_reg` latches into a shadow register the same edge. Later `seq_reg` changes do not affect the snapshot.
- Rejected trigger (engine busy, or full with OVERWRITE=0): no state change except `drop_cnt`+1.
- Accepted while full with OVERWRITE=1: tail advances and level decrements at the acceptance edge, and `drop_cnt`+1. Exception: if `pop` is asserted the same cycle, pop performs the advance and `drop_cnt` is unchanged.
- Write engine: `wr_active` is set for REG_NUM cycles. Shadow word `select` is written to RAM address `head_base+select`. `select` increments and returns to 0 after REG_NUM-1.
- Commit: at the edge ending the last write cycle, head advances and `level`+1.
- Head and tail are kept as slot indices plus running base registers (`base += REG_NUM`, wrap to 0 after slot SLOT_NUM-1). No multiplier is used.
- `pop` while empty is ignored. A simultaneous pop and commit leaves `level` unchanged.
- Read: RAM read address = `tail_base+reg_addr`. `reg_addr ≥ REG_NUM` or empty returns 0.
- Reset mid-write aborts the write. The partial slot is never committed.

## Timing
- Trigger accepted in cycle T. Writes occur in T+1…T+REG_NUM, with word i written in T+1+i. Commit is at the end of T+REG_NUM.
- The next trigger can be accepted in T+REG_NUM+1.
- `write_busy` is high from T through T+REG_NUM.
- Read: `reg_rd` in cycle R with a stable address gives `reg_ready`=1 and valid `reg_readdata` in R+1 (one-cycle RAM latency).
- `reg_ready` toggles while `reg_rd` is held, so the host must drop `reg_rd` after seeing ready. It returns to 0 the cycle after `reg_rd` deasserts.
- A pop in cycle P makes reads issued from P+1 onward address the new tail.
- `level`, `empty` and `full` are registered and update at the commit, pop or overwrite edge.

## Structure
- No typedefs. Only `DROP_CNT_W`=16 goes in the shared package. Derived widths are localparams in the module.
- One sub-module: the existing `rowo_dpram`, instantiated with rdw=wdw=DW and raw=aw. It is depth SLOT_NUM*REG_NUM, with read and write on `clk` and `rden`=1.
- Ring pointers and counters stay inline. No separate FIFO module is used.

## Test plan
- Single snapshot, REG_NUM=10, seq_reg word i=32'hA000+i. Pulse the trigger, then read offsets 0..9. Expect 32'hA000..A009, `level`=1, `write_busy` high for exactly 11 cycles.
- Coherence: change seq_reg to all-FFFF_FFFF at T+1. Expect the slot to hold the pre-trigger values.
- OVERWRITE=0, SLOT_NUM=8: 9 snapshots tagged 1..9. Expect `full`, `drop_cnt`=1, and after 8 pops the reads see tags 1..8, then `empty`.
- OVERWRITE=1, same stimulus: expect the oldest readable tag to be 2, `level`=8, `drop_cnt`=1. Repeat with a pop in the trigger cycle and expect `drop_cnt`=0.
- Trigger during busy, then a trigger 1 cycle after commit: expect `drop_cnt`=1 and the second trigger accepted. Pop at the commit edge leaves `level` unchanged.
- Assert `rst` at T+5: expect all outputs at reset values, `level`=0, and the next snapshot written to slot 0.
